// File: rtl/urv_dbg_uart_bridge_pkg.sv
// Shared constants and types for the UART-to-AHB-Lite debug bridge.
//   Command/response byte codes, AHB encodings, FSM state types and the
//   response byte selector used while streaming a reply.
package urv_dbg_uart_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_AHB_ADDR,
    ST_AHB_DATA,
    ST_SEND_RESP
  } bridge_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Byte idx of a reply: status first, then read data little-endian.
  function automatic logic [7:0] resp_byte(input logic [2:0] idx,
                                           input logic err,
                                           input logic [31:0] data);
    logic [7:0] b;
    case (idx)
      3'd0:    b = err ? RSP_ERR : RSP_OK;
      3'd1:    b = data[7:0];
      3'd2:    b = data[15:8];
      3'd3:    b = data[23:16];
      3'd4:    b = data[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/urv_dbg_uart_phy.sv
// 8N1 UART PHY for the debug bridge.
//   clk, rst       : system clock, synchronous active-high reset
//   uart_rx        : asynchronous receive line (idle high)
//   uart_tx        : transmit line (idle high)
//   rx_valid/rx_data/rx_ferr : one-cycle pulse per received byte / framing error
//   tx_start/tx_data/tx_busy : start a byte when not busy; busy until stop bit ends
module urv_dbg_uart_phy
  import urv_dbg_uart_bridge_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);

  logic             rx_s1, rx_s2, rx_s3;
  rx_state_t        rx_st;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_sh;

  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bit;
  logic [8:0]       tx_sh;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // Receiver: start re-checked at half bit, then data/stop sampled at bit centres.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st    <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_st)
        RX_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_st  <= RX_START;
            rx_cnt <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rx_s2 ? RX_IDLE : RX_DATA;  // glitch, not a start bit
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            rx_st  <= RX_IDLE;
            if (rx_s2) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_sh;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // Transmitter: tx_sh holds the bits still to go after the one on the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_tx <= 1'b1;
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
    end else if (!tx_busy) begin
      if (tx_start) begin
        uart_tx <= 1'b0;
        tx_sh   <= {1'b1, tx_data};
        tx_bit  <= '0;
        tx_cnt  <= '0;
        tx_busy <= 1'b1;
      end
    end else if (tx_cnt == BIT_LAST) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
        uart_tx <= 1'b1;
      end else begin
        uart_tx <= tx_sh[0];
        tx_sh   <= {1'b1, tx_sh[8:1]};
        tx_bit  <= tx_bit + 4'd1;
      end
    end else begin
      tx_cnt <= tx_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/urv_dbg_uart_bridge.sv
// UART-to-AHB-Lite debug host bridge.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   uart_rx_i, uart_tx_o : 8N1 command/response link
//   HADDR..HWDATA        : AHB-Lite master outputs (single 32-bit transfers)
//   HRDATA, HREADY, HRESP: AHB-Lite slave responses
//   busy_o               : frame in progress (parser not idle)
// Frames: 'W' ADDR[4] DATA[4] -> 'K'/'E';  'R' ADDR[4] -> 'K' DATA[4] / 'E'.
module urv_dbg_uart_bridge
  import urv_dbg_uart_bridge_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 16,
  parameter int unsigned TIMEOUT_BITS = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        busy_o
);

  localparam logic [31:0] TOUT_LAST = 32'(TIMEOUT_BITS * CLK_DIV - 1);

  bridge_state_t state;
  logic          cmd_wr;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          resp_err;
  logic [1:0]    byte_cnt;
  logic [2:0]    resp_idx;
  logic [2:0]    resp_len;
  logic [31:0]   tout_cnt;

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ferr;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;

  assign HSIZE    = HSIZE_WORD;
  assign HBURST   = HBURST_SINGLE;
  assign resp_len = (cmd_wr || resp_err) ? 3'd1 : 3'd5;

  urv_dbg_uart_phy #(
    .CLK_DIV (CLK_DIV)
  ) u_phy (
    .clk      (clk_i),
    .rst      (rst_i),
    .uart_rx  (uart_rx_i),
    .uart_tx  (uart_tx_o),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ferr  (rx_ferr),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

  // Frame parser, inter-byte timeout and AHB transfer sequencing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      cmd_wr   <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      rdata    <= '0;
      resp_err <= 1'b0;
      byte_cnt <= '0;
      resp_idx <= '0;
      tout_cnt <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      HADDR    <= '0;
      HTRANS   <= HTRANS_IDLE;
      HWRITE   <= 1'b0;
      HWDATA   <= '0;
      busy_o   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy_o <= 1'b0;
          if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
            cmd_wr   <= (rx_data == CMD_WR);
            byte_cnt <= '0;
            tout_cnt <= '0;
            busy_o   <= 1'b1;
            state    <= ST_GET_ADDR;
          end
        end

        ST_GET_ADDR: begin
          if (rx_ferr) begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end else if (rx_valid) begin
            addr     <= {rx_data, addr[31:8]};
            tout_cnt <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (cmd_wr) begin
                state <= ST_GET_DATA;
              end else begin
                // Low two address bits are dropped: word-aligned only.
                HADDR  <= {rx_data, addr[31:10], 2'b00};
                HTRANS <= HTRANS_NONSEQ;
                HWRITE <= 1'b0;
                state  <= ST_AHB_ADDR;
              end
            end
          end else if (tout_cnt == TOUT_LAST) begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            tout_cnt <= tout_cnt + 32'd1;
          end
        end

        ST_GET_DATA: begin
          if (rx_ferr) begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end else if (rx_valid) begin
            wdata    <= {rx_data, wdata[31:8]};
            tout_cnt <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              HADDR  <= {addr[31:2], 2'b00};
              HTRANS <= HTRANS_NONSEQ;
              HWRITE <= 1'b1;
              state  <= ST_AHB_ADDR;
            end
          end else if (tout_cnt == TOUT_LAST) begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            tout_cnt <= tout_cnt + 32'd1;
          end
        end

        ST_AHB_ADDR: begin
          if (HREADY) begin
            HTRANS <= HTRANS_IDLE;
            HWRITE <= 1'b0;
            if (cmd_wr) HWDATA <= wdata;
            state <= ST_AHB_DATA;
          end
        end

        ST_AHB_DATA: begin
          if (HREADY) begin
            rdata    <= HRDATA;
            resp_err <= HRESP;
            resp_idx <= '0;
            state    <= ST_SEND_RESP;
          end
        end

        ST_SEND_RESP: begin
          // tx_start is held off one extra cycle so tx_busy has time to rise.
          if (!tx_busy && !tx_start) begin
            if (resp_idx < resp_len) begin
              tx_start <= 1'b1;
              tx_data  <= resp_byte(resp_idx, resp_err, rdata);
              resp_idx <= resp_idx + 3'd1;
            end else begin
              busy_o <= 1'b0;
              state  <= ST_IDLE;
            end
          end
        end

        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_urv_dbg_uart_bridge.sv
// Directed bench for urv_dbg_uart_bridge: UART driver, UART monitor and an
// AHB-Lite slave model with programmable wait states and error response.
module tb_urv_dbg_uart_bridge;

  localparam int unsigned CLK_DIV      = 16;
  localparam int unsigned TIMEOUT_BITS = 64;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        uart_rx_i = 1'b1;
  logic        uart_tx_o;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = 32'h0;
  logic        HREADY = 1'b1;
  logic        HRESP  = 1'b0;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  urv_dbg_uart_bridge #(
    .CLK_DIV      (CLK_DIV),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .uart_rx_i (uart_rx_i),
    .uart_tx_o (uart_tx_o),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .busy_o    (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // AHB slave model, driven on the falling edge.
  int          sl_wait  = 0;
  logic [31:0] sl_rdata = 32'h0;
  logic        sl_err   = 1'b0;
  int          xfer_cnt = 0;
  logic [31:0] rec_addr  = 32'h0;
  logic        rec_write = 1'b0;
  logic [31:0] rec_wdata = 32'h0;
  logic        pend = 1'b0;
  int          wleft = 0;

  always @(negedge clk_i) begin
    if (rst_i) begin
      pend   = 1'b0;
      HREADY = 1'b1;
      HRESP  = 1'b0;
    end else if (pend) begin
      if (wleft > 0) begin
        HREADY = 1'b0;
        wleft--;
      end else begin
        HREADY    = 1'b1;
        HRDATA    = sl_rdata;
        HRESP     = sl_err;
        rec_wdata = HWDATA;
        pend      = 1'b0;
      end
    end else if (HTRANS == 2'b10 && HREADY) begin
      rec_addr  = HADDR;
      rec_write = HWRITE;
      xfer_cnt++;
      pend  = 1'b1;
      wleft = sl_wait;
    end else begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
    end
  end

  // UART monitor on the transmit line.
  logic [7:0] rxq[$];

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge uart_tx_o);
      repeat (CLK_DIV / 2) @(negedge clk_i);
      if (uart_tx_o == 1'b0) begin
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk_i);
          b = {uart_tx_o, b[7:1]};
        end
        repeat (CLK_DIV) @(negedge clk_i);
        if (uart_tx_o) rxq.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clk_i);
    uart_rx_i = 1'b0;
    repeat (CLK_DIV) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (CLK_DIV) @(negedge clk_i);
    end
    uart_rx_i = stop_ok;
    repeat (CLK_DIV) @(negedge clk_i);
    uart_rx_i = 1'b1;
    if (!stop_ok) repeat (CLK_DIV) @(negedge clk_i);
    repeat (2) @(negedge clk_i);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic send_wr(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57, 1'b1);
    send_word(a);
    send_word(d);
  endtask

  task automatic send_rd(input logic [31:0] a);
    send_byte(8'h52, 1'b1);
    send_word(a);
  endtask

  // Wait for n reply bytes and the bridge to go idle, then check the byte count.
  task automatic wait_done(input int n, input string tag);
    int cyc;
    cyc = 0;
    while (!(rxq.size() >= n && !busy_o) && cyc < 8000) begin
      @(negedge clk_i);
      cyc++;
    end
    repeat (2 * CLK_DIV) @(negedge clk_i);
    chk({tag, "_nbytes"}, 32'(rxq.size()), 32'(n));
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = 8'hxx;
    if (rxq.size() > 0) got = rxq.pop_front();
    chk(tag, {24'h0, got}, {24'h0, exp});
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_tx"},     {31'h0, uart_tx_o}, 32'h1);
    chk({tag, "_htrans"}, {30'h0, HTRANS},    32'h0);
    chk({tag, "_busy"},   {31'h0, busy_o},    32'h0);
  endtask

  task automatic pulse_rst;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    int cyc;

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_rst("reset");
    chk("reset_hwrite", {31'h0, HWRITE}, 32'h0);
    chk("reset_haddr",  HADDR,  32'h0);
    chk("reset_hwdata", HWDATA, 32'h0);
    chk("hsize",  {29'h0, HSIZE},  32'h2);
    chk("hburst", {29'h0, HBURST}, 32'h0);

    // Plain write.
    x0 = xfer_cnt;
    send_wr(32'h8000_0000, 32'h1234_5678);
    wait_done(1, "wr");
    chk("wr_xfers", 32'(xfer_cnt - x0), 32'd1);
    chk("wr_haddr", rec_addr, 32'h8000_0000);
    chk("wr_hwrite", {31'h0, rec_write}, 32'h1);
    chk("wr_hwdata", rec_wdata, 32'h1234_5678);
    pop_chk("wr_resp", 8'h4B);
    chk("wr_busy", {31'h0, busy_o}, 32'h0);

    // Read with three wait states.
    sl_wait  = 3;
    sl_rdata = 32'hDEAD_BEEF;
    x0 = xfer_cnt;
    send_rd(32'h8000_0004);
    wait_done(5, "rd");
    chk("rd_xfers", 32'(xfer_cnt - x0), 32'd1);
    chk("rd_haddr", rec_addr, 32'h8000_0004);
    chk("rd_hwrite", {31'h0, rec_write}, 32'h0);
    pop_chk("rd_b0", 8'h4B);
    pop_chk("rd_b1", 8'hEF);
    pop_chk("rd_b2", 8'hBE);
    pop_chk("rd_b3", 8'hAD);
    pop_chk("rd_b4", 8'hDE);

    // Error response on a read: status byte only.
    sl_wait = 0;
    sl_err  = 1'b1;
    send_rd(32'h8000_0010);
    wait_done(1, "err");
    pop_chk("err_resp", 8'h45);
    chk("err_busy", {31'h0, busy_o}, 32'h0);
    sl_err = 1'b0;

    // Unknown command, then a truncated read that must time out.
    x0 = xfer_cnt;
    send_byte(8'h00, 1'b1);
    chk("unk_busy", {31'h0, busy_o}, 32'h0);
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("tout_busy_early", {31'h0, busy_o}, 32'h1);
    repeat (60 * CLK_DIV) @(negedge clk_i);
    chk("tout_busy_60", {31'h0, busy_o}, 32'h1);
    repeat (10 * CLK_DIV) @(negedge clk_i);
    chk("tout_busy_70", {31'h0, busy_o}, 32'h0);
    chk("tout_xfers", 32'(xfer_cnt - x0), 32'd0);
    chk("tout_tx", 32'(rxq.size()), 32'd0);

    // Recovery read; low address bits are ignored.
    sl_rdata = 32'h0BAD_F00D;
    send_rd(32'h8000_000B);
    wait_done(5, "rec");
    chk("rec_haddr", rec_addr, 32'h8000_0008);
    pop_chk("rec_b0", 8'h4B);
    pop_chk("rec_b1", 8'h0D);
    pop_chk("rec_b2", 8'hF0);
    pop_chk("rec_b3", 8'hAD);
    pop_chk("rec_b4", 8'h0B);

    // Framing error on the third address byte.
    x0 = xfer_cnt;
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    chk("ferr_busy", {31'h0, busy_o}, 32'h0);
    repeat (4 * CLK_DIV) @(negedge clk_i);
    chk("ferr_xfers", 32'(xfer_cnt - x0), 32'd0);
    chk("ferr_tx", 32'(rxq.size()), 32'd0);
    sl_wait = 1;
    send_wr(32'h8000_0020, 32'hA5A5_5A5A);
    wait_done(1, "ferr_next");
    chk("ferr_next_addr", rec_addr, 32'h8000_0020);
    chk("ferr_next_wdata", rec_wdata, 32'hA5A5_5A5A);
    pop_chk("ferr_next_resp", 8'h4B);

    // Reset during GET_DATA.
    x0 = xfer_cnt;
    send_byte(8'h57, 1'b1);
    send_word(32'h8000_0000);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    chk("rst_gd_busy_before", {31'h0, busy_o}, 32'h1);
    pulse_rst();
    chk_rst("rst_gd");
    repeat (4 * CLK_DIV) @(negedge clk_i);
    chk("rst_gd_xfers", 32'(xfer_cnt - x0), 32'd0);

    // Reset during SEND_RESP, partway through the second reply byte.
    sl_wait  = 0;
    sl_rdata = 32'hCAFE_F00D;
    send_rd(32'h8000_0000);
    cyc = 0;
    while (rxq.size() < 1 && cyc < 8000) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("rst_sr_first", 32'(rxq.size()), 32'd1);
    repeat (3 * CLK_DIV) @(negedge clk_i);
    chk("rst_sr_busy_before", {31'h0, busy_o}, 32'h1);
    pulse_rst();
    chk_rst("rst_sr");
    repeat (20 * CLK_DIV) @(negedge clk_i);
    rxq.delete();

    // Bridge works after both resets.
    sl_wait = 2;
    send_wr(32'h8000_0004, 32'h0000_0001);
    wait_done(1, "post_rst");
    chk("post_rst_addr", rec_addr, 32'h8000_0004);
    chk("post_rst_wdata", rec_wdata, 32'h0000_0001);
    pop_chk("post_rst_resp", 8'h4B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
